// File: rtl/kmap_pkg.sv
// Shared types and sizing helpers for the K-map sweep checker.
package kmap_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int N_IN_DEF = 4;

  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

  // Mismatch counter must hold NVEC itself, so one bit wider than the index.
  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int tmr_w(input int settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// Settle down-counter: load_i sets SETTLE, en_i counts down, expire_o marks the last cycle.
// Latency: expire_o is asserted SETTLE enabled edges after a load; no backpressure.
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter  int SETTLE = 1,
  localparam int TW     = tmr_w(SETTLE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= TW'(SETTLE);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == TW'(1));

endmodule

// File: rtl/kmap_sweep_checker.sv
// Walks all 2**N_IN input vectors into a K-map function block, samples f after SETTLE cycles, scores vs. latched table.
// Latency: done pulses the cycle after edge start+NVEC*SETTLE; start is ignored while busy, abort cancels without done.
module kmap_sweep_checker
  import kmap_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEF,
  parameter  int SETTLE = 1,
  localparam int NVEC   = nvec(N_IN),
  localparam int CW     = cnt_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [NVEC-1:0] exp_tt,
  output logic [N_IN-1:0] vec_out,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   err_count,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_valid,
  output logic [NVEC-1:0] obs_tt
);

  state_e          state_q;
  logic [NVEC-1:0] exp_q;
  logic [NVEC-1:0] obs_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] first_idx_q;
  logic            first_vld_q;
  logic [CW-1:0]   err_q;
  logic [CW-1:0]   err_d;
  logic            done_q;
  logic            pass_q;

  logic mismatch;
  logic last_vec;
  logic tmr_expire;
  logic tmr_load;
  logic tmr_en;

  assign mismatch = f_in ^ exp_q[vec_q];
  assign last_vec = &vec_q;
  assign err_d    = err_q + {{N_IN{1'b0}}, mismatch};
  assign tmr_en   = (state_q == RUN) && !abort;
  assign tmr_load = ((state_q == IDLE) && start) || (tmr_expire && !last_vec);

  kmap_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      obs_q       <= '0;
      vec_q       <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      err_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            exp_q       <= exp_tt;
            obs_q       <= '0;
            vec_q       <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            err_q       <= '0;
            pass_q      <= 1'b0;
          end
        end
        RUN: begin
          // Abort wins over a sample landing on the same edge.
          if (abort) begin
            state_q     <= IDLE;
            obs_q       <= '0;
            vec_q       <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            err_q       <= '0;
            pass_q      <= 1'b0;
          end else if (tmr_expire) begin
            obs_q[vec_q] <= f_in;
            err_q        <= err_d;
            if (mismatch && !first_vld_q) begin
              first_idx_q <= vec_q;
              first_vld_q <= 1'b1;
            end
            if (last_vec) begin
              state_q <= IDLE;
              vec_q   <= '0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + N_IN'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_valid = first_vld_q;
  assign obs_tt          = obs_q;

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Bench for kmap_sweep_checker: instance 0 at SETTLE=1, instance 1 at SETTLE=3, scoreboard checks each done.
module tb_kmap_sweep_checker;

  typedef struct {
    int          inst;
    int          done_cyc;
    logic [15:0] obs;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic        fv;
    logic        ps;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start [2];
  logic        abort [2];
  logic        f_in [2];
  logic [15:0] exp_tt [2];
  logic [15:0] model_tt [2];
  logic [15:0] obs_tt [2];
  logic [3:0]  vec_out [2];
  logic [3:0]  first_err_idx [2];
  logic [4:0]  err_count [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic        first_err_valid [2];

  exp_t sb [$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_in[0] = model_tt[0][vec_out[0]];
  assign f_in[1] = model_tt[1][vec_out[1]];

  kmap_sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .exp_tt(exp_tt[0]),
    .vec_out(vec_out[0]), .f_in(f_in[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .first_err_idx(first_err_idx[0]),
    .first_err_valid(first_err_valid[0]), .obs_tt(obs_tt[0])
  );

  kmap_sweep_checker #(.N_IN(4), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .exp_tt(exp_tt[1]),
    .vec_out(vec_out[1]), .f_in(f_in[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .first_err_idx(first_err_idx[1]),
    .first_err_valid(first_err_valid[1]), .obs_tt(obs_tt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_vec_out"},  32'(vec_out[i]), 32'd0);
    chk({tag, "_busy"},     32'(busy[i]), 32'd0);
    chk({tag, "_done"},     32'(done[i]), 32'd0);
    chk({tag, "_pass"},     32'(pass[i]), 32'd0);
    chk({tag, "_err"},      32'(err_count[i]), 32'd0);
    chk({tag, "_fidx"},     32'(first_err_idx[i]), 32'd0);
    chk({tag, "_fvalid"},   32'(first_err_valid[i]), 32'd0);
    chk({tag, "_obs_tt"},   32'(obs_tt[i]), 32'd0);
  endtask

  // Call at a negedge: start is seen by the next posedge (E0); returns at the negedge after E0.
  task automatic issue(input int i, input logic [15:0] et, input logic [15:0] mt, output int c0);
    exp_tt[i]   = et;
    model_tt[i] = mt;
    start[i]    = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    c0 = cyc;
  endtask

  task automatic expect_sweep(input int i, input int done_cyc, input logic [15:0] obs,
                              input logic [4:0] err, input logic [3:0] fidx,
                              input logic fv, input logic ps);
    exp_t e;
    e.inst = i; e.done_cyc = done_cyc; e.obs = obs; e.err = err;
    e.fidx = fidx; e.fv = fv; e.ps = ps;
    sb.push_back(e);
  endtask

  task automatic wait_vec(input int i, input logic [3:0] v);
    int k;
    for (k = 0; k < 300; k++) begin
      if (busy[i] && vec_out[i] == v) break;
      @(negedge clk);
    end
    if (k == 300) chk("wait_vec_timeout", 32'(vec_out[i]), 32'(v));
  endtask

  task automatic wait_done(input int i);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done[i]) break;
      @(negedge clk);
    end
    if (k == 300) chk("wait_done_timeout", 32'(done[i]), 32'd1);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && done[i]) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done inst%0d: got done=1, expected none (cycle %0d)", i, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_inst",      32'(i), 32'(mon_e.inst));
          chk("sb_done_cyc",  32'(cyc), 32'(mon_e.done_cyc));
          chk("sb_obs_tt",    32'(obs_tt[i]), 32'(mon_e.obs));
          chk("sb_err_count", 32'(err_count[i]), 32'(mon_e.err));
          chk("sb_first_idx", 32'(first_err_idx[i]), 32'(mon_e.fidx));
          chk("sb_first_vld", 32'(first_err_valid[i]), 32'(mon_e.fv));
          chk("sb_pass",      32'(pass[i]), 32'(mon_e.ps));
          chk("sb_busy",      32'(busy[i]), 32'd0);
        end
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; exp_tt[i] = '0; model_tt[i] = '0;
    end
    #1 rst_n = 1'b0;
    #2;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: matching table
    issue(0, 16'hA5C3, 16'hA5C3, c0);
    expect_sweep(0, c0 + 16, 16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_vec_step", 32'(vec_out[0]), 32'(k));
      @(negedge clk);
    end
    wait_done(0);
    @(negedge clk);

    // 2: bit 6 flipped in the function
    issue(0, 16'hA5C3, 16'hA583, c0);
    expect_sweep(0, c0 + 16, 16'hA583, 5'd1, 4'd6, 1'b1, 1'b0);
    wait_done(0);
    @(negedge clk);

    // 3: all-zero expectation, f tied high
    issue(0, 16'h0000, 16'hFFFF, c0);
    expect_sweep(0, c0 + 16, 16'hFFFF, 5'd16, 4'd0, 1'b1, 1'b0);
    wait_done(0);
    chk("t3_done_width", 32'(done[0]), 32'd1);
    @(negedge clk);
    chk("t3_done_one_cycle", 32'(done[0]), 32'd0);
    chk("t3_results_hold", 32'(err_count[0]), 32'd16);

    // 4: SETTLE=3, then restart during the done cycle
    issue(1, 16'h1234, 16'h1234, c0);
    expect_sweep(1, c0 + 48, 16'h1234, 5'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      chk("t4_vec_hold3", 32'(vec_out[1]), 32'(k / 3));
      @(negedge clk);
    end
    wait_done(1);
    issue(1, 16'h0F0F, 16'h0F0E, c0);
    expect_sweep(1, c0 + 48, 16'h0F0E, 5'd1, 4'd0, 1'b1, 1'b0);
    chk("t4_restart_busy", 32'(busy[1]), 32'd1);
    chk("t4_restart_pass", 32'(pass[1]), 32'd0);
    chk("t4_restart_obs",  32'(obs_tt[1]), 32'd0);
    chk("t4_restart_err",  32'(err_count[1]), 32'd0);
    wait_done(1);
    @(negedge clk);

    // 5: start re-pulsed and exp_tt changed mid-sweep
    issue(0, 16'h3C96, 16'h3C96, c0);
    expect_sweep(0, c0 + 16, 16'h3C96, 5'd0, 4'd0, 1'b0, 1'b1);
    wait_vec(0, 4'd5);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t5_busy_kept", 32'(busy[0]), 32'd1);
    chk("t5_no_restart", 32'(vec_out[0]), 32'd6);
    wait_vec(0, 4'd8);
    exp_tt[0] = 16'hFFFF;
    wait_done(0);
    @(negedge clk);

    // 6a: abort at vector 9 (error already logged at vector 0)
    issue(0, 16'hA5C3, 16'hA5C2, c0);
    wait_vec(0, 4'd9);
    chk("t6_err_before_abort", 32'(err_count[0]), 32'd1);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk_zero(0, "t6_abort");
    repeat (20) @(negedge clk);
    chk("t6_idle_after_abort", 32'(busy[0]), 32'd0);

    // 6b: asynchronous reset at vector 3
    issue(0, 16'hA5C3, 16'h0000, c0);
    wait_vec(0, 4'd3);
    #2 rst_n = 1'b0;
    #1 chk_zero(0, "t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 16'h5A5A, 16'h5A5A, c0);
    expect_sweep(0, c0 + 16, 16'h5A5A, 5'd0, 4'd0, 1'b0, 1'b1);
    wait_done(0);
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
